xbar_bank_dispatch: RTL and testbench



---
 rtl/xbar_bank_dispatch_if.sv | 35 +++
 rtl/xbar_bank_dispatch.sv | 173 +++++++++++++++++
 tb/tb_xbar_bank_dispatch.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_bank_dispatch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xbar_bank_dispatch_if
// Brief    : Request bundle between the requester channels, the crossbar and the cache banks.
// Revision : 1.0 - initial release
// ============================================================================
interface xbar_bank_dispatch_if #(
  parameter int NUM_CH   = 3,
  parameter int NUM_BANK = 4,
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]       ch_req_valid_i;
  logic [NUM_CH-1:0]       ch_req_ready_o;
  logic [NUM_CH*AW-1:0]    ch_req_addr_i;
  logic [NUM_CH*DW-1:0]    ch_req_data_i;
  logic [NUM_BANK-1:0]     bank_req_valid_o;
  logic [NUM_BANK-1:0]     bank_req_ready_i;
  logic [NUM_BANK*AW-1:0]  bank_req_addr_o;
  logic [NUM_BANK*DW-1:0]  bank_req_data_o;
  logic [NUM_BANK*CHW-1:0] bank_req_ch_o;

  modport master (
    output ch_req_valid_i, ch_req_addr_i, ch_req_data_i, bank_req_ready_i,
    input  ch_req_ready_o, bank_req_valid_o, bank_req_addr_o, bank_req_data_o, bank_req_ch_o
  );

  modport slave (
    input  ch_req_valid_i, ch_req_addr_i, ch_req_data_i, bank_req_ready_i,
    output ch_req_ready_o, bank_req_valid_o, bank_req_addr_o, bank_req_data_o, bank_req_ch_o
  );
endinterface
`default_nettype wire

// File: rtl/xbar_bank_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xbar_bank_dispatch
// Brief    : Per-channel request queues issuing out of order across banks, with
//            per-bank round-robin arbitration, grant lock and in-order retire.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_bank_dispatch #(
  parameter int NUM_CH   = 3,
  parameter int NUM_BANK = 4,
  parameter int DEPTH    = 5,
  parameter int AW       = 32,
  parameter int DW       = 64
) (
  input wire                  clk_i,
  input wire                  rst_i,
  xbar_bank_dispatch_if.slave bus
);
  localparam int c_chw = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_bw  = $clog2(NUM_BANK);
  localparam int c_pw  = $clog2(DEPTH);
  localparam int c_cw  = $clog2(DEPTH + 1);

  // queue storage (payload only, never needs reset)
  logic [AW-1:0]       r_addr [NUM_CH][DEPTH];
  logic [DW-1:0]       r_data [NUM_CH][DEPTH];
  logic [c_bw-1:0]     r_bank [NUM_CH][DEPTH];
  // queue control
  logic [DEPTH-1:0]    r_alloc  [NUM_CH];
  logic [DEPTH-1:0]    r_pend   [NUM_CH];
  logic [c_pw-1:0]     r_wr_ptr [NUM_CH];
  logic [c_pw-1:0]     r_rd_ptr [NUM_CH];
  logic [c_cw-1:0]     r_cnt    [NUM_CH];
  // per-bank arbitration
  logic [c_chw-1:0]    r_rr      [NUM_BANK];
  logic [c_chw-1:0]    r_lock_ch [NUM_BANK];
  logic [NUM_BANK-1:0] r_lock;

  logic [NUM_BANK-1:0] w_cand_vld [NUM_CH];
  logic [c_pw-1:0]     w_cand_idx [NUM_CH][NUM_BANK];
  logic [c_chw-1:0]    w_win      [NUM_BANK];
  logic [NUM_BANK-1:0] w_bvalid;
  logic [NUM_BANK-1:0] w_hs;
  logic [NUM_CH-1:0]   w_full;
  logic [NUM_CH-1:0]   w_push;
  logic [NUM_CH-1:0]   w_retire;

  function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
    return (p == c_pw'(DEPTH - 1)) ? '0 : p + c_pw'(1);
  endfunction

  function automatic logic [c_chw-1:0] ch_inc(input logic [c_chw-1:0] p);
    return (p == c_chw'(NUM_CH - 1)) ? '0 : p + c_chw'(1);
  endfunction

  always_comb begin
    logic [c_pw:0]   w_sum;
    logic [c_pw-1:0] w_idx;
    w_sum = '0;
    w_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_cand_vld[c] = '0;
      for (int b = 0; b < NUM_BANK; b++) w_cand_idx[c][b] = '0;
      // walk youngest to oldest so the oldest pending match is written last
      for (int k = DEPTH - 1; k >= 0; k--) begin
        w_sum = {1'b0, r_rd_ptr[c]} + (c_pw + 1)'(k);
        if (w_sum >= (c_pw + 1)'(DEPTH)) w_sum = w_sum - (c_pw + 1)'(DEPTH);
        w_idx = w_sum[c_pw-1:0];
        if (r_pend[c][w_idx]) begin
          w_cand_vld[c][r_bank[c][w_idx]] = 1'b1;
          w_cand_idx[c][r_bank[c][w_idx]] = w_idx;
        end
      end
    end
  end

  always_comb begin
    logic [c_chw:0] w_c;
    w_c = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      w_win[b]    = r_lock_ch[b];
      w_bvalid[b] = r_lock[b] & w_cand_vld[r_lock_ch[b]][b];
      if (!r_lock[b]) begin
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          w_c = {1'b0, r_rr[b]} + (c_chw + 1)'(k);
          if (w_c >= (c_chw + 1)'(NUM_CH)) w_c = w_c - (c_chw + 1)'(NUM_CH);
          if (w_cand_vld[w_c[c_chw-1:0]][b]) begin
            w_win[b]    = w_c[c_chw-1:0];
            w_bvalid[b] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.bank_req_valid_o = w_bvalid;
    bus.bank_req_addr_o  = '0;
    bus.bank_req_data_o  = '0;
    bus.bank_req_ch_o    = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (w_bvalid[b]) begin
        bus.bank_req_addr_o[b*AW +: AW]     = r_addr[w_win[b]][w_cand_idx[w_win[b]][b]];
        bus.bank_req_data_o[b*DW +: DW]     = r_data[w_win[b]][w_cand_idx[w_win[b]][b]];
        bus.bank_req_ch_o[b*c_chw +: c_chw] = w_win[b];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_full[c]   = (r_cnt[c] == c_cw'(DEPTH));
      w_push[c]   = bus.ch_req_valid_i[c] & ~w_full[c];
      w_retire[c] = r_alloc[c][r_rd_ptr[c]] & ~r_pend[c][r_rd_ptr[c]];
    end
    bus.ch_req_ready_o = ~w_full;
    w_hs               = w_bvalid & bus.bank_req_ready_i;
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) begin
        r_addr[c][r_wr_ptr[c]] <= bus.ch_req_addr_i[c*AW +: AW];
        r_data[c][r_wr_ptr[c]] <= bus.ch_req_data_i[c*DW +: DW];
        r_bank[c][r_wr_ptr[c]] <= bus.ch_req_addr_i[c*AW +: c_bw];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_alloc[c]  <= '0;
        r_pend[c]   <= '0;
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_cnt[c]    <= '0;
      end
      for (int b = 0; b < NUM_BANK; b++) begin
        r_rr[b]      <= '0;
        r_lock_ch[b] <= '0;
      end
      r_lock <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) begin
          r_alloc[c][r_wr_ptr[c]] <= 1'b1;
          r_pend[c][r_wr_ptr[c]]  <= 1'b1;
          r_wr_ptr[c]             <= ptr_inc(r_wr_ptr[c]);
        end
        if (w_retire[c]) begin
          r_alloc[c][r_rd_ptr[c]] <= 1'b0;
          r_rd_ptr[c]             <= ptr_inc(r_rd_ptr[c]);
        end
        if (w_push[c] && !w_retire[c])      r_cnt[c] <= r_cnt[c] + c_cw'(1);
        else if (!w_push[c] && w_retire[c]) r_cnt[c] <= r_cnt[c] - c_cw'(1);
      end
      // a pushed slot is never the slot being granted, so these pend writes never collide
      for (int b = 0; b < NUM_BANK; b++) begin
        if (w_hs[b]) begin
          r_pend[w_win[b]][w_cand_idx[w_win[b]][b]] <= 1'b0;
          r_rr[b]   <= ch_inc(w_win[b]);
          r_lock[b] <= 1'b0;
        end else if (w_bvalid[b]) begin
          r_lock[b]    <= 1'b1;
          r_lock_ch[b] <= w_win[b];
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_xbar_bank_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xbar_bank_dispatch
// Brief    : Directed scenarios plus randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_bank_dispatch;
  localparam int NUM_CH   = 3;
  localparam int NUM_BANK = 4;
  localparam int DEPTH    = 5;
  localparam int AW       = 32;
  localparam int DW       = 64;
  localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xbar_bank_dispatch_if #(.NUM_CH(NUM_CH), .NUM_BANK(NUM_BANK), .AW(AW), .DW(DW)) bus ();

  xbar_bank_dispatch #(
    .NUM_CH(NUM_CH), .NUM_BANK(NUM_BANK), .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one ordered list of live requests per channel
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            issued;
  } ent_t;

  ent_t mq [NUM_CH][$];
  int   m_rr     [NUM_BANK];
  bit   m_lock   [NUM_BANK];
  int   m_lockch [NUM_BANK];
  bit   e_valid  [NUM_BANK];
  int   e_win    [NUM_BANK];
  int   e_idx    [NUM_BANK];

  function automatic int find_cand(input int c, input int b);
    for (int i = 0; i < mq[c].size(); i++)
      if (!mq[c][i].issued && int'(mq[c][i].addr % NUM_BANK) == b) return i;
    return -1;
  endfunction

  function automatic void model_eval();
    for (int b = 0; b < NUM_BANK; b++) begin
      int kmax;
      e_valid[b] = 1'b0; e_win[b] = 0; e_idx[b] = 0;
      kmax = m_lock[b] ? 1 : NUM_CH;
      for (int k = 0; k < kmax; k++) begin
        int ch; int i;
        ch = m_lock[b] ? m_lockch[b] : (m_rr[b] + k) % NUM_CH;
        i  = find_cand(ch, b);
        if (i >= 0 && !e_valid[b]) begin
          e_valid[b] = 1'b1; e_win[b] = ch; e_idx[b] = i;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    for (int b = 0; b < NUM_BANK; b++) begin
      m_rr[b] = 0; m_lock[b] = 1'b0; m_lockch[b] = 0;
    end
  endfunction

  function automatic void model_step();
    bit ret [NUM_CH];
    bit psh [NUM_CH];
    model_eval();
    for (int c = 0; c < NUM_CH; c++) begin
      ret[c] = (mq[c].size() > 0) && mq[c][0].issued;
      psh[c] = bus.ch_req_valid_i[c] && (mq[c].size() != DEPTH);
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      if (e_valid[b]) begin
        if (bus.bank_req_ready_i[b]) begin
          mq[e_win[b]][e_idx[b]].issued = 1'b1;
          m_rr[b]   = (e_win[b] + 1) % NUM_CH;
          m_lock[b] = 1'b0;
        end else begin
          m_lock[b]   = 1'b1;
          m_lockch[b] = e_win[b];
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      ent_t e;
      if (ret[c]) void'(mq[c].pop_front());
      if (psh[c]) begin
        e.addr = bus.ch_req_addr_i[c*AW +: AW];
        e.data = bus.ch_req_data_i[c*DW +: DW];
        e.issued = 1'b0;
        mq[c].push_back(e);
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- every-cycle comparison against the model
  always @(negedge clk) begin
    model_eval();
    for (int b = 0; b < NUM_BANK; b++) begin
      logic [AW-1:0] ea; logic [DW-1:0] ed; int ec;
      ea = '0; ed = '0; ec = 0;
      if (e_valid[b]) begin
        ea = mq[e_win[b]][e_idx[b]].addr;
        ed = mq[e_win[b]][e_idx[b]].data;
        ec = e_win[b];
      end
      chk($sformatf("bank%0d_valid", b), 64'(bus.bank_req_valid_o[b]), 64'(e_valid[b]));
      chk($sformatf("bank%0d_addr", b), 64'(bus.bank_req_addr_o[b*AW +: AW]), 64'(ea));
      chk($sformatf("bank%0d_data", b), bus.bank_req_data_o[b*DW +: DW], ed);
      chk($sformatf("bank%0d_ch", b), 64'(bus.bank_req_ch_o[b*CHW +: CHW]), 64'(ec));
    end
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("ch%0d_ready", c), 64'(bus.ch_req_ready_o[c]), 64'(mq[c].size() != DEPTH));
  end

  // ---------------- stimulus helpers
  task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ch_req_addr_i[c*AW +: AW] = a;
    bus.ch_req_data_i[c*DW +: DW] = d;
  endtask

  task automatic drain(input int n);
    bus.ch_req_valid_i   = '0;
    bus.bank_req_ready_i = '1;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] bdata(input int b);
    return bus.bank_req_data_o[b*DW +: DW];
  endfunction

  function automatic logic [CHW-1:0] bch(input int b);
    return bus.bank_req_ch_o[b*CHW +: CHW];
  endfunction

  int           grants [6];
  int           exp_gr [6];
  int           ngr;
  logic [DW-1:0] rx [12];
  int           nrx;
  logic [CHW-1:0] held_ch;
  logic [DW-1:0]  held_data;

  initial begin
    bus.ch_req_valid_i   = '0;
    bus.ch_req_addr_i    = '0;
    bus.ch_req_data_i    = '0;
    bus.bank_req_ready_i = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_bank_valid", 64'(bus.bank_req_valid_o), 64'h0);
    chk("reset_ch_ready", 64'(bus.ch_req_ready_o), 64'h7);
    chk("reset_bank_addr", bus.bank_req_addr_o[63:0], 64'h0);
    rst = 1'b0;

    // single request, bank2 stalled for three cycles
    bus.ch_req_valid_i = 3'b001;
    set_ch(0, 32'h2, 64'hA5);
    @(negedge clk);
    bus.ch_req_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      chk("single_valid", 64'(bus.bank_req_valid_o[2]), 64'h1);
      chk("single_ch", 64'(bch(2)), 64'h0);
      chk("single_addr", 64'(bus.bank_req_addr_o[2*AW +: AW]), 64'h2);
      chk("single_data", bdata(2), 64'hA5);
      @(negedge clk);
    end
    bus.bank_req_ready_i = 4'b0100;
    @(negedge clk);
    bus.bank_req_ready_i = 4'b0000;
    chk("single_done", 64'(bus.bank_req_valid_o[2]), 64'h0);
    drain(6);

    // full queue on ch1 towards a stalled bank0
    bus.bank_req_ready_i = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) chk("full_ready_low", 64'(bus.ch_req_ready_o[1]), 64'h0);
      set_ch(1, 32'(k * 4), 64'(k));
      bus.ch_req_valid_i = 3'b010;
      @(negedge clk);
    end
    chk("full_hold_ready_low", 64'(bus.ch_req_ready_o[1]), 64'h0);
    bus.ch_req_valid_i   = '0;
    bus.bank_req_ready_i = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      chk("full_order_valid", 64'(bus.bank_req_valid_o[0]), 64'h1);
      chk("full_order_data", bdata(0), 64'(k));
      @(negedge clk);
    end
    chk("full_ready_back", 64'(bus.ch_req_ready_o[1]), 64'h1);
    drain(6);

    // round robin on bank3 with a two-cycle stall
    bus.bank_req_ready_i = 4'b1000;
    bus.ch_req_valid_i   = 3'b111;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 32'h3 | 32'(c << 8), 64'(c * 16));
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 32'h3 | 32'(c << 8), 64'(c * 16 + 1));
    exp_gr = '{0, 1, 2, 0, 1, 2};
    ngr = 0;
    held_ch = '0; held_data = '0;
    for (int i = 0; i < 20 && ngr < 6; i++) begin
      if (i == 1) bus.ch_req_valid_i = '0;
      bus.bank_req_ready_i[3] = !(i == 2 || i == 3);
      if (i == 2) begin held_ch = bch(3); held_data = bdata(3); end
      if (i == 3 || i == 4) begin
        chk("rr_stall_ch", 64'(bch(3)), 64'(held_ch));
        chk("rr_stall_data", bdata(3), held_data);
      end
      if (bus.bank_req_valid_o[3] && bus.bank_req_ready_i[3]) begin
        grants[ngr] = int'(bch(3));
        ngr++;
      end
      @(negedge clk);
    end
    chk("rr_grant_count", 64'(ngr), 64'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(exp_gr[k]));
    drain(8);

    // out-of-order issue across banks on ch0
    bus.bank_req_ready_i = 4'b0100;
    bus.ch_req_valid_i   = 3'b001;
    set_ch(0, 32'h1, 64'hAAAA);
    @(negedge clk);
    set_ch(0, 32'h2, 64'hBBBB);
    @(negedge clk);
    bus.ch_req_valid_i = '0;
    chk("ooo_b_valid", 64'(bus.bank_req_valid_o[2]), 64'h1);
    chk("ooo_b_data", bdata(2), 64'hBBBB);
    chk("ooo_a_data", bdata(1), 64'hAAAA);
    @(negedge clk);
    chk("ooo_b_gone", 64'(bus.bank_req_valid_o[2]), 64'h0);
    chk("ooo_a_wait", 64'(bus.bank_req_valid_o[1]), 64'h1);
    bus.bank_req_ready_i = 4'b0010;
    @(negedge clk);
    chk("ooo_a_gone", 64'(bus.bank_req_valid_o[1]), 64'h0);
    drain(6);

    // wrap-around streaming on ch2 to bank1
    nrx = 0;
    for (int i = 0; i < 40 && nrx < 12; i++) begin
      if (i < 12) begin
        chk("wrap_ready", 64'(bus.ch_req_ready_o[2]), 64'h1);
        set_ch(2, 32'h1 | 32'(i << 4), 64'(i + 100));
        bus.ch_req_valid_i = 3'b100;
      end else begin
        bus.ch_req_valid_i = '0;
      end
      if (bus.bank_req_valid_o[1]) begin
        rx[nrx] = bdata(1);
        nrx++;
      end
      @(negedge clk);
    end
    chk("wrap_count", 64'(nrx), 64'd12);
    for (int k = 0; k < 12; k++) chk($sformatf("wrap_data%0d", k), rx[k], 64'(k + 100));
    drain(6);

    // asynchronous reset with pending entries and bank0 locked
    bus.bank_req_ready_i = '0;
    bus.ch_req_valid_i   = 3'b001;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 32'(k * 4), 64'(k + 50));
      @(negedge clk);
    end
    bus.ch_req_valid_i = '0;
    @(negedge clk);
    chk("rst_pre_valid", 64'(bus.bank_req_valid_o[0]), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(bus.bank_req_valid_o), 64'h0);
    chk("rst_async_ready", 64'(bus.ch_req_ready_o), 64'h7);
    chk("rst_async_data", bus.bank_req_data_o[63:0], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.ch_req_valid_i = 3'b101;
    set_ch(0, 32'h10, 64'h1);
    set_ch(2, 32'h20, 64'h2);
    @(negedge clk);
    bus.ch_req_valid_i = '0;
    chk("rst_first_arb_ch", 64'(bch(0)), 64'h0);
    chk("rst_first_arb_data", bdata(0), 64'h1);
    drain(8);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int mode;
      mode = (cyc / 500) % 3;
      bus.ch_req_valid_i = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) set_ch(c, $urandom, {$urandom, $urandom});
      for (int b = 0; b < NUM_BANK; b++) begin
        case (mode)
          0:       bus.bank_req_ready_i[b] = ($urandom_range(0, 3) != 0);
          1:       bus.bank_req_ready_i[b] = 1'($urandom_range(0, 1));
          default: bus.bank_req_ready_i[b] = ($urandom_range(0, 3) == 0);
        endcase
      end
      @(negedge clk);
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
